// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
//
// Eight-phase instruction sequencer for the basic CPU. A 3-bit phase counter
// walks through fetch (phases 0-3) and execute (phases 4-7). The control
// strobes are decoded from the phase, the opcode and the ALU zero flag. They
// steer the address mux, memory, instruction register, accumulator and
// program counter. HLT parks the sequencer in phase 4. A resume pulse
// restarts it from phase 0, but only when RESUME_EN=1.
//
// Parameters:
//   RESUME_EN - 1: resume leaves HALTED; 0: only reset leaves HALTED
//
// Ports:
//   clk     in   system clock, all state changes on posedge
//   rst     in   synchronous reset, active-low
//   opcode  in   [2:0] opcode (HLT,SKZ,ADD,AND,XOR,LDA,STO,JMP = 0..7)
//   zero    in   accumulator-zero flag from the ALU
//   resume  in   single-cycle pulse that restarts execution from HALTED
//   sel     out  address mux select (1 = PC, 0 = IR operand field)
//   rd      out  memory read enable
//   ld_ir   out  instruction register load
//   halt    out  processor halted indicator
//   inc_pc  out  program counter increment
//   ld_ac   out  accumulator load
//   ld_pc   out  program counter load (jump)
//   wr      out  memory write strobe
//   data_e  out  accumulator-to-data-bus drive enable
//   phase   out  [2:0] current phase, holds 4 while halted
// -----------------------------------------------------------------------------
module cpu_controller #(
    parameter bit RESUME_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       resume,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       wr,
    output logic       data_e,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    phase_e     r_phase;
    logic       r_halted;
    phase_e     w_phase_nxt;
    logic       w_halted_nxt;
    logic [2:0] w_phase_inc;
    logic       w_aluop;
    logic       w_is_hlt;
    logic       w_is_skz;
    logic       w_is_sto;
    logic       w_is_jmp;

    // Opcode classification shared by next-state and output decode
    assign w_aluop     = (opcode == OP_ADD) || (opcode == OP_AND) ||
                         (opcode == OP_XOR) || (opcode == OP_LDA);
    assign w_is_hlt    = (opcode == OP_HLT);
    assign w_is_skz    = (opcode == OP_SKZ);
    assign w_is_sto    = (opcode == OP_STO);
    assign w_is_jmp    = (opcode == OP_JMP);
    assign w_phase_inc = r_phase + 3'd1;

    // Phase and halted-flag registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_phase  <= PH_INST_ADDR;
            r_halted <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // Next-state logic: advance, enter HALTED on HLT, or leave it on resume
    always_comb begin
        w_phase_nxt  = r_phase;
        w_halted_nxt = r_halted;
        if (r_halted) begin
            if (RESUME_EN && resume) begin
                w_halted_nxt = 1'b0;
                w_phase_nxt  = PH_INST_ADDR;
            end else begin
                w_halted_nxt = 1'b1;
                w_phase_nxt  = PH_OP_ADDR;
            end
        end else if ((r_phase == PH_OP_ADDR) && w_is_hlt) begin
            // Resume in the entry cycle has no effect: the flag is not yet set.
            w_halted_nxt = 1'b1;
            w_phase_nxt  = PH_OP_ADDR;
        end else begin
            w_halted_nxt = 1'b0;
            w_phase_nxt  = phase_e'(w_phase_inc);
        end
    end

    // Output decode from phase, opcode, zero and halted flag
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        phase  = r_phase;
        if (r_halted) begin
            halt = 1'b1;
        end else begin
            case (r_phase)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    // PC steps past every opcode here, HLT included, so a
                    // later resume refetches the following instruction.
                    inc_pc = 1'b1;
                    halt   = w_is_hlt;
                end
                PH_OP_FETCH: begin
                    rd = w_aluop;
                end
                PH_ALU_OP: begin
                    rd     = w_aluop;
                    inc_pc = w_is_skz && zero;
                    ld_pc  = w_is_jmp;
                    data_e = w_is_sto;
                end
                PH_STORE: begin
                    rd     = w_aluop;
                    ld_ac  = w_aluop;
                    ld_pc  = w_is_jmp;
                    data_e = w_is_sto;
                    wr     = w_is_sto;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       resume;

    logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
    logic [2:0] phase;
    logic       sel0, rd0, ld_ir0, halt0, inc_pc0, ld_ac0, ld_pc0, wr0, data_e0;
    logic [2:0] phase0;

    cpu_controller #(.RESUME_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .resume(resume),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt), .inc_pc(inc_pc),
        .ld_ac(ld_ac), .ld_pc(ld_pc), .wr(wr), .data_e(data_e), .phase(phase)
    );

    cpu_controller #(.RESUME_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .resume(resume),
        .sel(sel0), .rd(rd0), .ld_ir(ld_ir0), .halt(halt0), .inc_pc(inc_pc0),
        .ld_ac(ld_ac0), .ld_pc(ld_pc0), .wr(wr0), .data_e(data_e0), .phase(phase0)
    );

    // Strobe bit positions within {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e}
    localparam logic [8:0] S_NONE = 9'b0_0000_0000;
    localparam logic [8:0] S_SEL  = 9'b1_0000_0000;
    localparam logic [8:0] S_RD   = 9'b0_1000_0000;
    localparam logic [8:0] S_LDIR = 9'b0_0100_0000;
    localparam logic [8:0] S_HALT = 9'b0_0010_0000;
    localparam logic [8:0] S_INC  = 9'b0_0001_0000;
    localparam logic [8:0] S_LDAC = 9'b0_0000_1000;
    localparam logic [8:0] S_LDPC = 9'b0_0000_0100;
    localparam logic [8:0] S_WR   = 9'b0_0000_0010;
    localparam logic [8:0] S_DE   = 9'b0_0000_0001;

    // Hand-written per-phase strobe tables, packed {ph3,ph2,ph1,ph0} / {ph7,ph6,ph5,ph4}
    localparam logic [35:0] FETCH   = {S_SEL | S_RD | S_LDIR, S_SEL | S_RD | S_LDIR, S_SEL | S_RD, S_SEL};
    localparam logic [35:0] BK_ALU  = {S_RD | S_LDAC, S_RD, S_RD, S_INC};
    localparam logic [35:0] BK_STO  = {S_DE | S_WR, S_DE, S_NONE, S_INC};
    localparam logic [35:0] BK_JMP  = {S_LDPC, S_LDPC, S_NONE, S_INC};
    localparam logic [35:0] BK_SKZ1 = {S_NONE, S_INC, S_NONE, S_INC};
    localparam logic [35:0] BK_SKZ0 = {S_NONE, S_NONE, S_NONE, S_INC};
    localparam logic [11:0] EH      = {S_HALT, 3'd4};

    logic [11:0] exp_q  [$];
    logic [11:0] exp0_q [$];
    int          checks;
    int          errors;
    logic        dut0_halt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every cycle both DUTs present outputs; compare against scoreboard
    always @(negedge clk) begin
        logic [11:0] e;
        logic [11:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, phase};
            checks = checks + 1;
            if (a !== e) begin
                errors = errors + 1;
                $display("FAIL dut_outputs t=%0t: got %b required %b", $time, a, e);
            end
        end
        if (exp0_q.size() > 0) begin
            e = exp0_q.pop_front();
            a = {sel0, rd0, ld_ir0, halt0, inc_pc0, ld_ac0, ld_pc0, wr0, data_e0, phase0};
            checks = checks + 1;
            if (a !== e) begin
                errors = errors + 1;
                $display("FAIL dut0_outputs t=%0t: got %b required %b", $time, a, e);
            end
        end
    end

    // Drive one cycle of inputs and record what each DUT must show in it
    task automatic cyc(input logic [2:0] op, input logic z, input logic res,
                       input logic r, input logic [11:0] e, input logic [11:0] e0);
        opcode = op;
        zero   = z;
        resume = res;
        rst    = r;
        exp_q.push_back(e);
        exp0_q.push_back(e0);
        @(posedge clk);
        #1;
    endtask

    // Run nph phases of one instruction, starting from phase 0
    task automatic run_instr(input logic [2:0] op, input logic [7:0] zv, input logic [7:0] rv,
                             input logic [7:0] rstv, input int nph, input logic [35:0] back);
        logic [8:0]  s;
        logic [11:0] e;
        logic [11:0] e0;
        for (int p = 0; p < nph; p++) begin
            if (p < 4) s = FETCH[p*9 +: 9];
            else       s = back[(p-4)*9 +: 9];
            e  = {s, 3'(p)};
            e0 = dut0_halt ? EH : e;
            cyc(op, zv[p], rv[p], rstv[p], e, e0);
        end
    endtask

    // Fetch and execute HLT, then hold in HALTED for a number of cycles
    task automatic halt_instr(input logic res_entry, input int hold);
        logic [11:0] e;
        for (int p = 0; p < 4; p++) begin
            e = {FETCH[p*9 +: 9], 3'(p)};
            cyc(3'd0, 1'b0, 1'b0, 1'b1, e, dut0_halt ? EH : e);
        end
        e = {S_HALT | S_INC, 3'd4};
        cyc(3'd0, 1'b0, res_entry, 1'b1, e, dut0_halt ? EH : e);
        dut0_halt = 1'b1;
        for (int i = 0; i < hold; i++) begin
            cyc(3'(i), i[0], 1'b0, 1'b1, EH, EH);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        dut0_halt = 1'b0;
        rst       = 1'b0;
        opcode    = 3'd0;
        zero      = 1'b0;
        resume    = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // ADD with a stray resume in phase 2 and zero wiggling: no effect
        run_instr(3'd2, 8'b0100_0000, 8'b0000_0100, 8'hFF, 8, BK_ALU);
        run_instr(3'd6, 8'h5A, 8'h00, 8'hFF, 8, BK_STO);
        run_instr(3'd7, 8'h00, 8'h00, 8'hFF, 8, BK_JMP);
        run_instr(3'd3, 8'hFF, 8'h00, 8'hFF, 8, BK_ALU);
        run_instr(3'd4, 8'h00, 8'h00, 8'hFF, 8, BK_ALU);
        // SKZ: zero high in phase 6, toggled in 5 and 7
        run_instr(3'd1, 8'b0110_0010, 8'h00, 8'hFF, 8, BK_SKZ1);
        run_instr(3'd1, 8'b1010_0000, 8'h00, 8'hFF, 8, BK_SKZ0);

        // HLT with resume coinciding with entry: still halts
        halt_instr(1'b1, 10);
        // Resume pulse: dut restarts, dut0 (RESUME_EN=0) stays halted
        cyc(3'd5, 1'b0, 1'b1, 1'b1, EH, EH);
        run_instr(3'd5, 8'h00, 8'h00, 8'hFF, 8, BK_ALU);
        halt_instr(1'b0, 3);

        // Reset together with resume while halted: both go to phase 0
        cyc(3'd2, 1'b0, 1'b1, 1'b0, EH, EH);
        dut0_halt = 1'b0;
        // Reset mid-JMP in phase 6, then phases 0 and 1 with ld_pc low
        run_instr(3'd7, 8'h00, 8'h00, 8'b1011_1111, 7, BK_JMP);
        run_instr(3'd7, 8'h00, 8'h00, 8'hFF, 2, BK_JMP);

        @(negedge clk);
        #1;
        checks = checks + 1;
        if ((exp_q.size() != 0) || (exp0_q.size() != 0)) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: got %0d/%0d pending required 0/0",
                     exp_q.size(), exp0_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
